frequency_band_analyzer: RTL

Multi-band successor of the two-tone frequency analyzer. It measures every half-period of a 1-bit input: the time between consecutive edges of the synchronised signal, in clock cycles. Each half-period is classified into one of NUM_BANDS runtime-programmable bands, or into "other". Classified cycle counts accumulate over a fixed measurement window, then are published as a result set with a one-cycle valid strobe. It sits between the raw capture pin and the mode/decoder logic of the image capture path.

---
 rtl/frequency_band_pkg.sv | 28 ++
 rtl/band_classifier.sv | 39 +++
 rtl/frequency_band_analyzer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/frequency_band_pkg.sv
// Shared types and helpers for the frequency band analyzer:
// state encoding, saturation limits and the per-band match rule.
package frequency_band_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // Band comparisons run at this width, so TICK_WIDTH must not exceed it.
    localparam int MATCH_WIDTH = 32;

    function automatic logic [63:0] sat_value(input int width);
        return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic band_match(
        input logic [MATCH_WIDTH-1:0] measured,
        input logic [MATCH_WIDTH-1:0] hp,
        input logic [MATCH_WIDTH-1:0] tol
    );
        logic [MATCH_WIDTH-1:0] diff;
        diff = (measured >= hp) ? (measured - hp) : (hp - measured);
        return (hp != '0) && (diff <= tol);
    endfunction

endpackage

// File: rtl/band_classifier.sv
// Combinational priority classifier: finds the lowest-index band whose
// centre/tolerance window contains the measured half-period.
module band_classifier
    import frequency_band_pkg::*;
#(
    parameter int NUM_BANDS  = 4,
    parameter int TICK_WIDTH = 16,
    localparam int IDX_W     = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic [TICK_WIDTH-1:0]           measured,
    input  logic                            saturated,
    input  logic [NUM_BANDS*TICK_WIDTH-1:0] band_half_period,
    input  logic [NUM_BANDS*TICK_WIDTH-1:0] band_tolerance,
    output logic [NUM_BANDS-1:0]            hit,
    output logic [IDX_W-1:0]                band_index,
    output logic                            other
);

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
            hit[i] = band_match(MATCH_WIDTH'(measured),
                                MATCH_WIDTH'(band_half_period[i*TICK_WIDTH +: TICK_WIDTH]),
                                MATCH_WIDTH'(band_tolerance[i*TICK_WIDTH +: TICK_WIDTH]));
        end
    end

    // Scanning downwards leaves the lowest matching index as the winner.
    always_comb begin
        band_index = '0;
        for (int i = NUM_BANDS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                band_index = IDX_W'(i);
            end
        end
        other = saturated || (hit == '0);
    end

endmodule

// File: rtl/frequency_band_analyzer.sv
// Multi-band half-period analyzer: synchronises sample_data, measures the time between
// edges, classifies each half-period into a band and publishes per-window totals.
module frequency_band_analyzer
    import frequency_band_pkg::*;
#(
    parameter int NUM_BANDS    = 4,
    parameter int TICK_WIDTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int WINDOW_TICKS = 50000000
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic                            clear,
    input  logic                            sample_data,
    input  logic [NUM_BANDS*TICK_WIDTH-1:0] band_half_period,
    input  logic [NUM_BANDS*TICK_WIDTH-1:0] band_tolerance,
    output logic [NUM_BANDS*ACC_WIDTH-1:0]  band_ticks,
    output logic [ACC_WIDTH-1:0]            other_ticks,
    output logic                            result_valid,
    output logic                            overflow
);

    localparam int WIN_W = (WINDOW_TICKS > 2) ? $clog2(WINDOW_TICKS) : 1;
    localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int SUM_W = ((ACC_WIDTH > TICK_WIDTH) ? ACC_WIDTH : TICK_WIDTH) + 1;
    localparam logic [WIN_W-1:0]      WIN_LAST  = WIN_W'(WINDOW_TICKS - 1);
    localparam logic [TICK_WIDTH-1:0] TICK_MAX  = TICK_WIDTH'(sat_value(TICK_WIDTH));
    localparam logic [ACC_WIDTH-1:0]  ACC_MAX   = ACC_WIDTH'(sat_value(ACC_WIDTH));
    localparam logic [SUM_W-1:0]      SUM_LIMIT = SUM_W'(ACC_MAX);

    state_t state, next_state;
    logic sync1, sync2, sync3, sig_edge;
    logic window_run, capture, flush, window_end;
    logic [WIN_W-1:0] window_cnt;
    logic [TICK_WIDTH-1:0] period_cnt, meas_value, cls_value;
    logic meas_valid, cls_valid;
    logic [NUM_BANDS-1:0] band_hit, win_onehot, cls_sel;
    logic [IDX_W-1:0] band_index;
    logic band_other;
    logic [NUM_BANDS-1:0][ACC_WIDTH-1:0] acc_band, band_next;
    logic [ACC_WIDTH-1:0] acc_other, other_next;
    logic sticky, sticky_next;
    logic [SUM_W-1:0] sum;

    assign sig_edge   = sync2 ^ sync3;
    assign flush      = !enable || clear;
    assign window_end = window_run && !flush && (window_cnt == WIN_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= sample_data;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else if (clear) begin
            next_state = ARM;
        end else begin
            case (state)
                IDLE:    next_state = ARM;
                ARM:     next_state = sig_edge ? MEASURE : ARM;
                MEASURE: next_state = MEASURE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        window_run = 1'b0;
        capture    = 1'b0;
        case (state)
            ARM:     window_run = 1'b1;
            MEASURE: begin
                window_run = 1'b1;
                capture    = sig_edge;
            end
            default: ;
        endcase
    end

    // The arming edge only starts the count; later edges close a half-period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
        end else if (flush || state == IDLE) begin
            period_cnt <= '0;
        end else if (sig_edge) begin
            period_cnt <= TICK_WIDTH'(1);
        end else if (state == MEASURE && period_cnt != TICK_MAX) begin
            period_cnt <= period_cnt + TICK_WIDTH'(1);
        end
    end

    band_classifier #(
        .NUM_BANDS  (NUM_BANDS),
        .TICK_WIDTH (TICK_WIDTH)
    ) u_classifier (
        .measured         (meas_value),
        .saturated        (meas_value == TICK_MAX),
        .band_half_period (band_half_period),
        .band_tolerance   (band_tolerance),
        .hit              (band_hit),
        .band_index       (band_index),
        .other            (band_other)
    );

    assign win_onehot = band_other ? '0 : ((NUM_BANDS'(1) << band_index) & band_hit);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meas_valid <= 1'b0;
            meas_value <= '0;
            cls_valid  <= 1'b0;
            cls_value  <= '0;
            cls_sel    <= '0;
        end else if (flush) begin
            meas_valid <= 1'b0;
            meas_value <= '0;
            cls_valid  <= 1'b0;
            cls_value  <= '0;
            cls_sel    <= '0;
        end else begin
            meas_valid <= capture;
            if (capture) begin
                meas_value <= period_cnt;
            end
            cls_valid <= meas_valid;
            cls_value <= meas_value;
            cls_sel   <= win_onehot;
        end
    end

    // An all-zero select means the half-period belongs to "other".
    always_comb begin
        band_next   = acc_band;
        other_next  = acc_other;
        sticky_next = sticky;
        sum         = '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
            if (cls_valid && cls_sel[i]) begin
                sum = SUM_W'(acc_band[i]) + SUM_W'(cls_value);
                if (sum > SUM_LIMIT) begin
                    band_next[i] = ACC_MAX;
                    sticky_next  = 1'b1;
                end else begin
                    band_next[i] = ACC_WIDTH'(sum);
                end
            end
        end
        if (cls_valid && cls_sel == '0) begin
            sum = SUM_W'(acc_other) + SUM_W'(cls_value);
            if (sum > SUM_LIMIT) begin
                other_next  = ACC_MAX;
                sticky_next = 1'b1;
            end else begin
                other_next = ACC_WIDTH'(sum);
            end
        end
    end

    // At the window end the same-cycle add goes into the published set, not the new window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_band     <= '0;
            acc_other    <= '0;
            sticky       <= 1'b0;
            window_cnt   <= '0;
            band_ticks   <= '0;
            other_ticks  <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (flush || !window_run) begin
                acc_band   <= '0;
                acc_other  <= '0;
                sticky     <= 1'b0;
                window_cnt <= '0;
            end else if (window_end) begin
                band_ticks   <= band_next;
                other_ticks  <= other_next;
                overflow     <= sticky_next;
                result_valid <= 1'b1;
                acc_band     <= '0;
                acc_other    <= '0;
                sticky       <= 1'b0;
                window_cnt   <= '0;
            end else begin
                acc_band   <= band_next;
                acc_other  <= other_next;
                sticky     <= sticky_next;
                window_cnt <= window_cnt + WIN_W'(1);
            end
        end
    end

endmodule
